systolic_result_drain: RTL and testbench



---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_result_drain_if.sv | 37 +++
 rtl/result_skid_fifo.sv | 47 ++++
 rtl/systolic_result_drain.sv | 121 ++++++++++++
 tb/tb_systolic_result_drain.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and sizing helpers for the systolic array blocks
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  localparam int DEFAULT_ACC_WIDTH = 32;

  function automatic int row_width(input int n_size, input int acc_width);
    return n_size * acc_width;
  endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// rtl/systolic_result_drain_if.sv - result buffer read port plus row output stream
interface systolic_result_drain_if
  import systolic_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_WIDTH  = row_width(32, DEFAULT_ACC_WIDTH)
);

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [ROW_WIDTH-1:0]  mem_rd_data;
  logic                  out_valid;
  logic [ROW_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_skid_fifo.sv
// rtl/result_skid_fifo.sv - 2-entry skid FIFO holding {last, row} entries
module result_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ_q;
  logic             pop_ok;
  logic             push_ok;

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  assign pop_ok  = pop && (occ_q != 2'd0);
  assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      occ_q <= occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head = mem[rd_ptr];
  assign occ  = occ_q;

endmodule

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - reads a tile of result rows in address order and streams them out
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int N_SIZE     = 32,
  parameter int NUM_ROWS   = 512,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_rows,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  systolic_result_drain_if.master bus
);

  localparam int ROW_WIDTH = row_width(N_SIZE, ACC_WIDTH);
  localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH+1)'(NUM_ROWS);

  drain_state_t          state_q;
  drain_state_t          state_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_clamped;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  done_q;

  logic [1:0]            occ;
  logic [ROW_WIDTH:0]    head;
  logic                  head_last;
  logic                  pop;
  logic                  rd_en;
  logic                  last_rd;
  logic                  start_ok;
  logic [2:0]            level;

  assign count_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  assign start_ok      = (state_q == IDLE) && start;
  assign head_last     = head[ROW_WIDTH];
  assign pop           = bus.out_valid && bus.out_ready;
  assign last_rd       = ({1'b0, addr_q} == (count_q - 1'b1));

  // Occupancy the FIFO will have once this cycle's push/pop settle; a new read
  // is only safe if its data will still find a free slot next cycle.
  assign level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (count_clamped != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_en = (level < 3'd2);
        if (rd_en && last_rd) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        count_q <= count_clamped;
      end
      // Clearing on the final read keeps the address from ever wrapping.
      if (rd_en) begin
        addr_q <= last_rd ? '0 : addr_q + 1'b1;
      end
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && last_rd;
      done_q          <= (start_ok && (count_clamped == '0)) ||
                         ((state_q == FLUSH) && pop && head_last);
    end
  end

  result_skid_fifo #(
    .WIDTH(ROW_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_last_q, bus.mem_rd_data}),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = addr_q;
  assign bus.out_valid   = (occ != 2'd0);
  assign bus.out_data    = head[ROW_WIDTH-1:0];
  assign bus.out_last    = bus.out_valid && head_last;

  assign ready = (state_q == IDLE);
  assign busy  = !ready;
  assign done  = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - directed bench for systolic_result_drain
module tb_systolic_result_drain;

  localparam int RW = 1024;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [AW:0] num_rows;
  logic        ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  systolic_result_drain_if #(.ADDR_WIDTH(AW), .ROW_WIDTH(RW)) bus ();

  systolic_result_drain #(
    .ACC_WIDTH (32),
    .N_SIZE    (32),
    .NUM_ROWS  (512),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .num_rows(num_rows),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row_val(input int i);
    logic [RW-1:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = (32'(i) << 12) ^ 32'(k) ^ 32'hC0DE0000;
    return r;
  endfunction

  // Result buffer model: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= row_val(int'(bus.mem_rd_addr));
    else               bus.mem_rd_data <= {32{32'hDEADBEEF}};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic [AW:0] nrows;
    logic        ordy;
    logic        e_rd_en;
    logic [AW-1:0] e_addr;
    logic        e_valid;
    int          e_row;   // -1: all zero, -2: don't care
    logic        e_last;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input int n, input logic o,
                              input logic en, input int a, input logic v, input int row,
                              input logic l, input logic rdy, input logic b, input logic d);
    vec_t x;
    x.rst = r; x.start = s; x.nrows = (AW+1)'(n); x.ordy = o;
    x.e_rd_en = en; x.e_addr = AW'(a); x.e_valid = v; x.e_row = row;
    x.e_last = l; x.e_ready = rdy; x.e_busy = b; x.e_done = d;
    return x;
  endfunction

  // Full drain with monitoring; coll >= 0 pulses an extra start (num_rows=2) in that cycle.
  task automatic drain(input int nreq, input int exp_rows, input int mode, input int coll);
    int reads, pops, dones, order_err, last_err, stable_err, addr_err, max_out, last_addr;
    bit seen_done;
    logic held, hlast;
    logic [RW-1:0] hdata;
    logic [11:0] pat;
    reads = 0; pops = 0; dones = 0; order_err = 0; last_err = 0; stable_err = 0;
    addr_err = 0; max_out = 0; last_addr = -1; seen_done = 0; held = 0;
    hlast = 0; hdata = '0;
    pat = 12'b1100_0101_1001;
    for (int cyc = 0; cyc < exp_rows * 4 + 40 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == 0) || (cyc == coll);
      num_rows  = (cyc == coll) ? (AW+1)'(2) : (AW+1)'(nreq);
      out_ready_set((mode == 0) ? 1'b1 : pat[cyc % 12]);
      @(negedge clk);
      if (held && (bus.out_valid !== 1'b1 || bus.out_data !== hdata || bus.out_last !== hlast))
        stable_err++;
      if (bus.mem_rd_en) begin
        if (bus.mem_rd_addr !== AW'(reads)) addr_err++;
        last_addr = int'(bus.mem_rd_addr);
        reads++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data !== row_val(pops)) order_err++;
        if (bus.out_last !== (pops == exp_rows - 1)) last_err++;
        pops++;
      end
      held  = bus.out_valid && !bus.out_ready;
      hdata = bus.out_data;
      hlast = bus.out_last;
      if (reads - pops > max_out) max_out = reads - pops;
      if (done) begin
        dones++;
        seen_done = 1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready_set(1'b1);
    @(negedge clk);
    if (done) dones++;
    chk("drain_completed", seen_done, 1'b1);
    chk("drain_reads", reads, exp_rows);
    chk("drain_rows_out", pops, exp_rows);
    chk("drain_done_count", dones, 1);
    chk("drain_order_errs", order_err, 0);
    chk("drain_last_errs", last_err, 0);
    chk("drain_stall_unstable", stable_err, 0);
    chk("drain_addr_errs", addr_err, 0);
    chk("drain_outstanding_le2", (max_out <= 2), 1'b1);
    chk("drain_last_addr", last_addr, exp_rows - 1);
    chk("drain_ready_after", ready, 1'b1);
  endtask

  task automatic out_ready_set(input logic v);
    bus.out_ready = v;
  endtask

  initial begin
    int pops, dones;
    bit any_rd, seen;
    rst = 1'b1; start = 1'b0; num_rows = '0;
    bus.out_ready = 1'b1;

    // Nominal drain of 4 rows; first row is the reset-state check.
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, -1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 4, 1, 0, 0, 0, -1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 4, 1, 1, 0, 0, -1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 1, 1, 1, 0, -1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 1, 1, 2, 1,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 1, 1, 3, 1,  1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 1, 0, 0, 1,  2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 1, 0, 0, 1,  3, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4, 1, 0, 0, 0, -2, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4, 1, 0, 0, 0, -2, 0, 1, 0, 0));

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; start = vecs[i].start; num_rows = vecs[i].nrows;
      bus.out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_mem_rd_en", i), bus.mem_rd_en, vecs[i].e_rd_en);
      chk($sformatf("v%0d_mem_rd_addr", i), bus.mem_rd_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_out_last", i), bus.out_last, vecs[i].e_last);
      chk($sformatf("v%0d_ready", i), ready, vecs[i].e_ready);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      if (vecs[i].e_row == -1) chk_row($sformatf("v%0d_out_data", i), bus.out_data, '0);
      else if (vecs[i].e_row >= 0)
        chk_row($sformatf("v%0d_out_data", i), bus.out_data, row_val(vecs[i].e_row));
    end

    // Backpressure, clamp, and a start pulse ignored mid-drain.
    drain(8, 8, 1, -1);
    drain(600, 512, 0, -1);
    drain(6, 6, 0, 3);

    // Zero-row drain: no reads, done one cycle after start.
    any_rd = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = (c == 0); num_rows = '0; bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.mem_rd_en) any_rd = 1;
      chk($sformatf("zero_done_c%0d", c), done, (c == 1));
      chk($sformatf("zero_ready_c%0d", c), ready, 1'b1);
    end
    chk("zero_no_reads", any_rd, 1'b0);

    // start in the done cycle chains a new drain.
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == 5);
      num_rows = (c == 5) ? (AW+1)'(3) : (AW+1)'(2);
      @(negedge clk);
      if (c == 5) chk("chain_done_c5", done, 1'b1);
      if (c == 6) begin
        chk("chain_rd_en_c6", bus.mem_rd_en, 1'b1);
        chk("chain_addr_c6", bus.mem_rd_addr, 0);
        chk("chain_busy_c6", busy, 1'b1);
      end
    end
    pops = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        chk_row($sformatf("chain_row%0d", pops), bus.out_data, row_val(pops));
        pops++;
      end
      if (done) seen = 1;
    end
    chk("chain_done_seen", seen, 1'b1);
    chk("chain_rows", pops, 3);

    // Reset after 5 rows of a 16-row drain.
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start = (c == 0); num_rows = (AW+1)'(16); bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) pops++;
    end
    chk("rst_rows_before", pops, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_rd_en", bus.mem_rd_en, 1'b0);
    chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk_row("rst_out_data", bus.out_data, '0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done) dones++;
      if (bus.mem_rd_en) dones += 100;
    end
    chk("rst_no_done_or_reads", dones, 0);
    drain(2, 2, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
